sram_burst_ctrl: RTL and testbench
==================================

SRAM_BURST_CTRL -- requirements
Module: sram_burst_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 i_clk  input  1  clock; all state changes on its rising edge.
REQ-003 i_rst  input  1  synchronous active-high reset.
REQ-004 i_req_valid  input  1  burst request valid.
REQ-005 o_req_ready  output  1  burst request accepted when valid and ready are both high.
REQ-006 i_req_wr  input  1  1 = write burst, 0 = read burst.
REQ-007 i_req_addr  input  6  start word address.
REQ-008 i_req_len  input  4  beats minus one (1..16 beats).
REQ-009 i_wdata  input  64  write beat data.
REQ-010 i_wdata_valid  input  1  write beat valid.
REQ-011 o_wdata_ready  output  1  write beat accepted when valid and ready are both high.
REQ-012 o_rdata  output  64  read beat data.
REQ-013 o_rdata_valid  output  1  read beat valid.
REQ-014 i_rdata_ready  input  1  read beat consumed when valid and ready are both high.
REQ-015 o_busy  output  1  high whenever the state is not IDLE.
REQ-016 o_sram_data  output  64  SRAM write data.
REQ-017 o_sram_addr  output  6  SRAM word address.
REQ-018 o_sram_cen  output  1  SRAM chip enable, active-high.
REQ-019 o_sram_wen  output  1  SRAM write enable, active-high (1 = write).
REQ-020 o_sram_oen  output  1  SRAM output enable, active-high.
REQ-021 i_sram_data  input  64  SRAM read data, valid the cycle after a read access.

Function
REQ-022 FSM states SHALL be IDLE, WRITE, READ and DRAIN.
REQ-023 o_req_ready SHALL be high only in IDLE. On acceptance the block latches addr and len:
- i_req_wr=1 -> WRITE
- i_req_wr=0 -> READ
REQ-024 WRITE: o_wdata_ready SHALL be high. Each wdata handshake drives the following combinationally in that same cycle:
- o_sram_cen=1, o_sram_wen=1, o_sram_oen=0
- o_sram_addr = current address
- o_sram_data = i_wdata
REQ-025 The current address SHALL increment by 1 modulo 64 after each issued beat (63 -> 0 wrap).
REQ-026 After the (len+1)th write beat, the state SHALL return to IDLE on the next cycle.
REQ-027 READ: a read access (o_sram_cen=1, o_sram_wen=0, o_sram_oen=1, o_sram_addr = current address) SHALL issue in a cycle only if (buffer entries after this cycle's pop) + (reads in flight) < 2.
REQ-028 Read data SHALL be captured from i_sram_data one cycle after issue into a 2-entry FIFO that drives o_rdata/o_rdata_valid.
- Beat order = address order.
- o_rdata SHALL be held stable while valid and not ready.
REQ-029 With i_rdata_ready held high, read throughput SHALL be one beat per cycle. The first o_rdata_valid SHALL rise 2 cycles after request acceptance.
REQ-030 After the last read issues: READ -> DRAIN. DRAIN -> IDLE when nothing is in flight and the FIFO is empty after this cycle's pop.
REQ-031 When no access issues: o_sram_cen=0, o_sram_wen=0, o_sram_oen=0, o_sram_addr=0, o_sram_data=0.
REQ-032 i_wdata_valid outside WRITE and i_req_valid outside IDLE SHALL be ignored, with no state change.

Reset
REQ-033 While i_rst is high, the following SHALL hold:
- State = IDLE; beat counter, address and FIFO cleared; in-flight flag cleared.
- Outputs: o_req_ready=0, o_wdata_ready=0, o_rdata_valid=0, o_rdata=0, o_busy=0, all o_sram_* = 0.
REQ-034 Reset asserted mid-burst SHALL abort the burst; no SRAM access issues in that cycle or after it. Captured data SHALL be discarded.
REQ-035 After reset deasserts, o_req_ready=1 from the first cycle.

Verification
REQ-036 Write then read, len=3, addr=6'h10, data A0..A3, i_rdata_ready=1 -> writes to addresses 10..13. Read beats A0..A3 on 4 consecutive cycles; first valid 2 cycles after acceptance.
REQ-037 Wrap, len=2, addr=6'h3F, write then read -> accesses at addresses 3F, 00, 01; read data returns in the same order.
REQ-038 Read len=15 with i_rdata_ready low for 5 cycles mid-burst -> at most 2 beats buffered, no beat lost or duplicated, all 16 beats in order; o_sram_cen low while stalled.
REQ-039 Write len=3 with i_wdata_valid gapped (1,0,1,1,0,1) -> exactly 4 writes, only in valid cycles; IDLE one cycle after the 4th.
REQ-040 Reset asserted at the 2nd beat of a read len=7 -> next cycle all outputs 0. A new write req to addr 0 completes normally.
REQ-041 i_req_valid held high during a busy burst -> second request not accepted until o_req_ready returns; then accepted exactly once.

Source files
------------

// File: rtl/sram_burst_ctrl_if.sv
// rtl/sram_burst_ctrl_if.sv - request, beat and SRAM bus bundle for sram_burst_ctrl
// Groups the burst request channel, the write and read beat streams, the busy
// flag and the SRAM pins. The slave modport is the controller's view and the
// master modport is the requester/SRAM side.
interface sram_burst_ctrl_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_wr;
  logic [5:0]  i_req_addr;
  logic [3:0]  i_req_len;
  logic [63:0] i_wdata;
  logic        i_wdata_valid;
  logic        o_wdata_ready;
  logic [63:0] o_rdata;
  logic        o_rdata_valid;
  logic        i_rdata_ready;
  logic        o_busy;
  logic [63:0] o_sram_data;
  logic [5:0]  o_sram_addr;
  logic        o_sram_cen;
  logic        o_sram_wen;
  logic        o_sram_oen;
  logic [63:0] i_sram_data;

  modport slave (
    input  i_req_valid, i_req_wr, i_req_addr, i_req_len,
    input  i_wdata, i_wdata_valid, i_rdata_ready, i_sram_data,
    output o_req_ready, o_wdata_ready, o_rdata, o_rdata_valid, o_busy,
    output o_sram_data, o_sram_addr, o_sram_cen, o_sram_wen, o_sram_oen
  );

  modport master (
    output i_req_valid, i_req_wr, i_req_addr, i_req_len,
    output i_wdata, i_wdata_valid, i_rdata_ready, i_sram_data,
    input  o_req_ready, o_wdata_ready, o_rdata, o_rdata_valid, o_busy,
    input  o_sram_data, o_sram_addr, o_sram_cen, o_sram_wen, o_sram_oen
  );
endinterface

// File: rtl/sram_burst_ctrl.sv
// rtl/sram_burst_ctrl.sv - burst controller turning 1..16 beat requests into SRAM accesses
// Ports: i_clk (rising edge), i_rst (synchronous, active-high), bus (slave view of
// sram_burst_ctrl_if: request handshake, write beat stream, read beat stream
// through a 2-entry FIFO, busy flag, SRAM pins with one-cycle read latency).
module sram_burst_ctrl (
  input  logic             i_clk,
  input  logic             i_rst,
  sram_burst_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  addr_q, addr_d;
  logic [3:0]  cnt_q, cnt_d;        // beats still to issue, minus one
  logic        inflight_q, inflight_d;
  logic [63:0] mem_q [2];
  logic [63:0] mem_d [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        rdata_valid;
  logic        pop;
  logic [2:0]  occ_after;           // FIFO entries after this pop plus reads in flight

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    inflight_d = 1'b0;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    mem_d      = mem_q;

    bus.o_req_ready   = 1'b0;
    bus.o_wdata_ready = 1'b0;
    bus.o_sram_cen    = 1'b0;
    bus.o_sram_wen    = 1'b0;
    bus.o_sram_oen    = 1'b0;
    bus.o_sram_addr   = '0;
    bus.o_sram_data   = '0;

    rdata_valid       = (count_q != 2'd0);
    pop               = rdata_valid && bus.i_rdata_ready;
    occ_after         = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    bus.o_rdata_valid = rdata_valid;
    bus.o_rdata       = rdata_valid ? mem_q[rd_ptr_q] : '0;
    bus.o_busy        = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        bus.o_req_ready = 1'b1;
        if (bus.i_req_valid) begin
          addr_d  = bus.i_req_addr;
          cnt_d   = bus.i_req_len;
          state_d = bus.i_req_wr ? WRITE : READ;
        end
      end
      WRITE: begin
        bus.o_wdata_ready = 1'b1;
        if (bus.i_wdata_valid) begin
          bus.o_sram_cen  = 1'b1;
          bus.o_sram_wen  = 1'b1;
          bus.o_sram_addr = addr_q;
          bus.o_sram_data = bus.i_wdata;
          addr_d          = addr_q + 6'd1;
          cnt_d           = cnt_q - 4'd1;
          if (cnt_q == 4'd0) state_d = IDLE;
        end
      end
      READ: begin
        // Only issue when the returning beat is guaranteed a FIFO slot.
        if (occ_after < 3'd2) begin
          bus.o_sram_cen  = 1'b1;
          bus.o_sram_oen  = 1'b1;
          bus.o_sram_addr = addr_q;
          inflight_d      = 1'b1;
          addr_d          = addr_q + 6'd1;
          cnt_d           = cnt_q - 4'd1;
          if (cnt_q == 4'd0) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (occ_after == 3'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (pop) rd_ptr_d = ~rd_ptr_q;
    // SRAM data is valid the cycle after the access, which is when inflight_q is set.
    if (inflight_q) begin
      mem_d[wr_ptr_q] = bus.i_sram_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};

    // Reset forces every output low combinationally, aborting any access this cycle.
    if (i_rst) begin
      bus.o_req_ready   = 1'b0;
      bus.o_wdata_ready = 1'b0;
      bus.o_rdata_valid = 1'b0;
      bus.o_rdata       = '0;
      bus.o_busy        = 1'b0;
      bus.o_sram_cen    = 1'b0;
      bus.o_sram_wen    = 1'b0;
      bus.o_sram_oen    = 1'b0;
      bus.o_sram_addr   = '0;
      bus.o_sram_data   = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= '0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      mem_q[0]   <= mem_d[0];
      mem_q[1]   <= mem_d[1];
    end
  end
endmodule

// File: tb/tb_sram_burst_ctrl.sv
// tb/tb_sram_burst_ctrl.sv - directed self-checking bench for sram_burst_ctrl
module tb_sram_burst_ctrl;
  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  sram_burst_ctrl_if bus ();

  sram_burst_ctrl dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: unwritten words return a recognisable address-derived pattern.
  logic [63:0] sram [64];
  bit          written [64];
  always @(posedge clk) begin
    if (bus.o_sram_cen && bus.o_sram_wen) begin
      sram[bus.o_sram_addr]    <= bus.o_sram_data;
      written[bus.o_sram_addr] <= 1'b1;
    end
    if (bus.o_sram_cen && bus.o_sram_oen)
      bus.i_sram_data <= written[bus.o_sram_addr] ? sram[bus.o_sram_addr]
                                                  : (64'hC0DE_0000_0000_0000 | {58'd0, bus.o_sram_addr});
  end

  // Read-burst driver results (filled by do_read, checked by each test).
  logic [5:0]  rd_iss_addr [$];
  logic [63:0] rd_beats [$];
  int          rd_stall_cen, rd_max_out, rd_unstable, rd_first_valid;
  int          rd_pop_first, rd_pop_last;
  bit          rd_done, rd_accepted;

  // Cycle 0 is the acceptance cycle; later cycles are numbered from it.
  task automatic do_read(input logic [5:0] a, input logic [3:0] len,
                         input int stall_from, input int stall_to);
    int issued, popped;
    logic [63:0] last;
    bit last_stalled;
    rd_iss_addr.delete();
    rd_beats.delete();
    rd_stall_cen = 0; rd_max_out = 0; rd_unstable = 0; rd_first_valid = -1;
    rd_pop_first = -1; rd_pop_last = -1; rd_done = 1'b0;
    issued = 0; popped = 0; last = '0; last_stalled = 1'b0;
    @(negedge clk);
    bus.i_req_valid = 1'b1; bus.i_req_wr = 1'b0;
    bus.i_req_addr = a; bus.i_req_len = len; bus.i_rdata_ready = 1'b1;
    #1;
    rd_accepted = bus.o_req_ready;
    for (int cyc = 1; cyc < 80 && !rd_done; cyc++) begin
      @(negedge clk);
      bus.i_req_valid   = 1'b0;
      bus.i_rdata_ready = !(cyc >= stall_from && cyc <= stall_to);
      #1;
      if (bus.o_rdata_valid && rd_first_valid < 0) rd_first_valid = cyc;
      if (last_stalled && bus.o_rdata !== last) rd_unstable++;
      if (bus.o_sram_cen) begin
        rd_iss_addr.push_back(bus.o_sram_addr);
        issued++;
        if (!bus.i_rdata_ready) rd_stall_cen++;
      end
      if (bus.o_rdata_valid && bus.i_rdata_ready) begin
        rd_beats.push_back(bus.o_rdata);
        popped++;
        if (rd_pop_first < 0) rd_pop_first = cyc;
        rd_pop_last = cyc;
      end
      if (issued - popped > rd_max_out) rd_max_out = issued - popped;
      last_stalled = bus.o_rdata_valid && !bus.i_rdata_ready;
      last = bus.o_rdata;
      if (!bus.o_busy) rd_done = 1'b1;
    end
    bus.i_rdata_ready = 1'b1;
  endtask

  task automatic test_reset();
    logic [140:0] outs;
    rst = 1'b1;
    bus.i_req_valid = 1'b1; bus.i_req_wr = 1'b1; bus.i_req_addr = 6'h05; bus.i_req_len = 4'd2;
    bus.i_wdata = 64'hDEAD; bus.i_wdata_valid = 1'b1; bus.i_rdata_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    outs = {bus.o_req_ready, bus.o_wdata_ready, bus.o_rdata_valid, bus.o_rdata, bus.o_busy,
            bus.o_sram_data, bus.o_sram_addr, bus.o_sram_cen, bus.o_sram_wen, bus.o_sram_oen};
    tests_run++;
    if (outs !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs got %h expected 0", outs);
    end
    @(negedge clk);
    rst = 1'b0; bus.i_req_valid = 1'b0; bus.i_wdata_valid = 1'b0;
    #1;
    tests_run++;
    if ({bus.o_req_ready, bus.o_busy, bus.o_sram_cen} !== 3'b100) begin
      tests_failed++;
      $display("FAIL reset_release got ready/busy/cen %b expected 100",
               {bus.o_req_ready, bus.o_busy, bus.o_sram_cen});
    end
  endtask

  task automatic test_write_read();
    logic [73:0] got, exp;
    @(negedge clk);
    bus.i_req_valid = 1'b1; bus.i_req_wr = 1'b1; bus.i_req_addr = 6'h10; bus.i_req_len = 4'd3;
    #1;
    tests_run++;
    if (bus.o_req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL wr_accept got %b expected 1", bus.o_req_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.i_req_valid = 1'b0; bus.i_wdata = 64'hA0 + 64'(i); bus.i_wdata_valid = 1'b1;
      #1;
      got = {bus.o_wdata_ready, bus.o_sram_cen, bus.o_sram_wen, bus.o_sram_oen, bus.o_sram_addr, bus.o_sram_data};
      exp = {1'b1, 1'b1, 1'b1, 1'b0, 6'h10 + 6'(i), 64'hA0 + 64'(i)};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL wr_beat%0d got %h expected %h", i, got, exp);
      end
    end
    @(negedge clk);
    bus.i_wdata_valid = 1'b0;
    #1;
    tests_run++;
    if ({bus.o_busy, bus.o_req_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL wr_idle got busy/ready %b expected 01", {bus.o_busy, bus.o_req_ready});
    end
    do_read(6'h10, 4'd3, 99, 99);
    tests_run++;
    if (!rd_done || !rd_accepted || rd_iss_addr.size() != 4 || rd_beats.size() != 4) begin
      tests_failed++;
      $display("FAIL rd_shape got done=%0d acc=%0d issues=%0d beats=%0d expected 1 1 4 4",
               rd_done, rd_accepted, rd_iss_addr.size(), rd_beats.size());
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (rd_iss_addr[i] !== 6'h10 + 6'(i) || rd_beats[i] !== 64'hA0 + 64'(i)) begin
        tests_failed++;
        $display("FAIL rd_beat%0d got addr %h data %h expected %h %h", i, rd_iss_addr[i], rd_beats[i],
                 6'h10 + 6'(i), 64'hA0 + 64'(i));
      end
    end
    // Acceptance edge ends cycle 0; valid rises two edges later and shows in cycle 3.
    tests_run++;
    if (rd_first_valid != 3 || rd_pop_last - rd_pop_first != 3) begin
      tests_failed++;
      $display("FAIL rd_latency got first=%0d span=%0d expected 3 3", rd_first_valid, rd_pop_last - rd_pop_first);
    end
  endtask

  task automatic test_wrap();
    logic [5:0] ea;
    @(negedge clk);
    bus.i_req_valid = 1'b1; bus.i_req_wr = 1'b1; bus.i_req_addr = 6'h3F; bus.i_req_len = 4'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.i_req_valid = 1'b0; bus.i_wdata = 64'hB0 + 64'(i); bus.i_wdata_valid = 1'b1;
      #1;
      ea = 6'h3F + 6'(i);
      tests_run++;
      if ({bus.o_sram_cen, bus.o_sram_wen, bus.o_sram_addr} !== {2'b11, ea}) begin
        tests_failed++;
        $display("FAIL wrap_wr%0d got cen/wen/addr %b %b %h expected 1 1 %h", i,
                 bus.o_sram_cen, bus.o_sram_wen, bus.o_sram_addr, ea);
      end
    end
    @(negedge clk);
    bus.i_wdata_valid = 1'b0;
    do_read(6'h3F, 4'd2, 99, 99);
    tests_run++;
    if (!rd_done || rd_iss_addr.size() != 3 || rd_beats.size() != 3) begin
      tests_failed++;
      $display("FAIL wrap_rd_shape got done=%0d issues=%0d beats=%0d expected 1 3 3",
               rd_done, rd_iss_addr.size(), rd_beats.size());
    end
    for (int i = 0; i < 3; i++) begin
      ea = 6'h3F + 6'(i);
      tests_run++;
      if (rd_iss_addr[i] !== ea || rd_beats[i] !== 64'hB0 + 64'(i)) begin
        tests_failed++;
        $display("FAIL wrap_rd%0d got addr %h data %h expected %h %h", i, rd_iss_addr[i], rd_beats[i],
                 ea, 64'hB0 + 64'(i));
      end
    end
  endtask

  task automatic test_long_read_stall();
    int bad;
    do_read(6'h20, 4'd15, 6, 10);
    tests_run++;
    if (!rd_done || rd_iss_addr.size() != 16 || rd_beats.size() != 16) begin
      tests_failed++;
      $display("FAIL stall_shape got done=%0d issues=%0d beats=%0d expected 1 16 16",
               rd_done, rd_iss_addr.size(), rd_beats.size());
    end
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (rd_iss_addr[i] !== 6'h20 + 6'(i) ||
          rd_beats[i] !== (64'hC0DE_0000_0000_0000 | 64'(6'h20 + 6'(i)))) bad++;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL stall_order got %0d wrong beats expected 0", bad);
    end
    tests_run++;
    if (rd_stall_cen != 0 || rd_unstable != 0 || rd_max_out > 2 || rd_first_valid != 3) begin
      tests_failed++;
      $display("FAIL stall_flow got cen_in_stall=%0d unstable=%0d max_out=%0d first=%0d expected 0 0 <=2 3",
               rd_stall_cen, rd_unstable, rd_max_out, rd_first_valid);
    end
  endtask

  task automatic test_gapped_write();
    int pat [6] = '{1, 0, 1, 1, 0, 1};
    int beat;
    logic [70:0] got, exp;
    beat = 0;
    @(negedge clk);
    bus.i_req_valid = 1'b1; bus.i_req_wr = 1'b1; bus.i_req_addr = 6'h30; bus.i_req_len = 4'd3;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.i_req_valid = 1'b0; bus.i_wdata_valid = pat[k][0]; bus.i_wdata = 64'hD0 + 64'(beat);
      #1;
      got = {bus.o_sram_cen, bus.o_sram_addr, bus.o_sram_data};
      exp = pat[k][0] ? {1'b1, 6'h30 + 6'(beat), 64'hD0 + 64'(beat)} : 71'd0;
      tests_run++;
      if (got !== exp || bus.o_wdata_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL gap_cyc%0d got %h wready=%b expected %h wready=1", k, got, bus.o_wdata_ready, exp);
      end
      if (pat[k] == 1) beat++;
    end
    @(negedge clk);
    bus.i_wdata_valid = 1'b1; bus.i_wdata = 64'hBAD;
    #1;
    tests_run++;
    if ({bus.o_busy, bus.o_sram_cen} !== 2'b00) begin
      tests_failed++;
      $display("FAIL gap_idle got busy/cen %b expected 00", {bus.o_busy, bus.o_sram_cen});
    end
    bus.i_wdata_valid = 1'b0;
    do_read(6'h30, 4'd3, 99, 99);
    tests_run++;
    if (rd_beats.size() != 4 || rd_beats[0] !== 64'hD0 || rd_beats[3] !== 64'hD3) begin
      tests_failed++;
      $display("FAIL gap_readback got n=%0d first %h last %h expected 4 d0 d3",
               rd_beats.size(), rd_beats[0], rd_beats[3]);
    end
  endtask

  task automatic test_reset_mid();
    logic [140:0] outs;
    @(negedge clk);
    bus.i_req_valid = 1'b1; bus.i_req_wr = 1'b0; bus.i_req_addr = 6'h20; bus.i_req_len = 4'd7;
    bus.i_rdata_ready = 1'b1;
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    #1;
    tests_run++;
    if ({bus.o_sram_cen, bus.o_sram_addr} !== {1'b1, 6'h20}) begin
      tests_failed++;
      $display("FAIL rmid_first got cen/addr %b %h expected 1 20", bus.o_sram_cen, bus.o_sram_addr);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    outs = {bus.o_req_ready, bus.o_wdata_ready, bus.o_rdata_valid, bus.o_rdata, bus.o_busy,
            bus.o_sram_data, bus.o_sram_addr, bus.o_sram_cen, bus.o_sram_wen, bus.o_sram_oen};
    tests_run++;
    if (outs !== '0) begin
      tests_failed++;
      $display("FAIL rmid_zero got %h expected 0", outs);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if ({bus.o_busy, bus.o_rdata_valid, bus.o_sram_cen, bus.o_req_ready} !== 4'b0001) begin
      tests_failed++;
      $display("FAIL rmid_after got busy/rv/cen/ready %b expected 0001",
               {bus.o_busy, bus.o_rdata_valid, bus.o_sram_cen, bus.o_req_ready});
    end
    @(negedge clk);
    #1;
    tests_run++;
    if ({bus.o_busy, bus.o_rdata_valid} !== 2'b00) begin
      tests_failed++;
      $display("FAIL rmid_discard got busy/rv %b expected 00", {bus.o_busy, bus.o_rdata_valid});
    end
    bus.i_req_valid = 1'b1; bus.i_req_wr = 1'b1; bus.i_req_addr = 6'h00; bus.i_req_len = 4'd0;
    @(negedge clk);
    bus.i_req_valid = 1'b0; bus.i_wdata = 64'hE0; bus.i_wdata_valid = 1'b1;
    #1;
    tests_run++;
    if ({bus.o_sram_cen, bus.o_sram_wen, bus.o_sram_addr, bus.o_sram_data} !== {2'b11, 6'h00, 64'hE0}) begin
      tests_failed++;
      $display("FAIL rmid_write got cen/wen/addr/data %b %b %h %h expected 1 1 00 e0",
               bus.o_sram_cen, bus.o_sram_wen, bus.o_sram_addr, bus.o_sram_data);
    end
    @(negedge clk);
    bus.i_wdata_valid = 1'b0;
    do_read(6'h00, 4'd0, 99, 99);
    tests_run++;
    if (rd_beats.size() != 1 || rd_beats[0] !== 64'hE0) begin
      tests_failed++;
      $display("FAIL rmid_readback got n=%0d data %h expected 1 e0", rd_beats.size(), rd_beats[0]);
    end
  endtask

  task automatic test_req_hold();
    int acc, wbeats, ready_busy, wr_acc;
    int acc_cyc [2];
    logic [63:0] got [$];
    acc = 0; wbeats = 0; ready_busy = 0; wr_acc = 0;
    acc_cyc[0] = -1; acc_cyc[1] = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      bus.i_req_valid = (acc < 2);
      bus.i_req_wr = (acc == 0);
      bus.i_req_addr = 6'h38; bus.i_req_len = 4'd1;
      bus.i_wdata_valid = 1'b1;
      bus.i_wdata = (wbeats == 0) ? 64'hF0 : 64'hF1;
      bus.i_rdata_ready = 1'b1;
      #1;
      if (bus.o_req_ready && bus.o_busy) ready_busy++;
      if (bus.o_sram_cen && bus.o_sram_wen) wr_acc++;
      if (bus.o_wdata_ready && bus.i_wdata_valid) wbeats++;
      if (bus.o_rdata_valid) got.push_back(bus.o_rdata);
      if (bus.i_req_valid && bus.o_req_ready) begin
        acc_cyc[acc] = cyc;
        acc++;
      end
    end
    bus.i_wdata_valid = 1'b0;
    tests_run++;
    if (acc_cyc[0] != 0 || acc_cyc[1] != 3 || ready_busy != 0) begin
      tests_failed++;
      $display("FAIL hold_accept got cycles %0d %0d ready_while_busy=%0d expected 0 3 0",
               acc_cyc[0], acc_cyc[1], ready_busy);
    end
    tests_run++;
    if (wr_acc != 2 || wbeats != 2 || got.size() != 2 || got[0] !== 64'hF0 || got[1] !== 64'hF1) begin
      tests_failed++;
      $display("FAIL hold_data got writes=%0d wbeats=%0d beats=%0d first %h expected 2 2 2 f0",
               wr_acc, wbeats, got.size(), got[0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_write_read();
    test_wrap();
    test_long_read_stall();
    test_gapped_write();
    test_reset_mid();
    test_req_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
